// File: rtl/mem_wb_stage_pkg.sv
// Instruction-type codes, write-back range limits and mux codes shared by the MEM/WB stage.
// The values mirror the core's tools/def.v and add the individual load codes INS_LB..INS_LW.
package mem_wb_stage_pkg;

    localparam logic [5:0] INS_NOP     = 6'd0;
    localparam logic [5:0] RCAL_BEGIN  = 6'd1;
    localparam logic [5:0] INS_ADD     = 6'd1;
    localparam logic [5:0] SHIFT_BEGIN = 6'd11;
    localparam logic [5:0] INS_SLL     = 6'd15;
    localparam logic [5:0] SHIFT_END   = 6'd15;

    localparam logic [5:0] LOAD_BEGIN  = 6'd16;
    localparam logic [5:0] INS_LB      = 6'd16;
    localparam logic [5:0] INS_LBU     = 6'd17;
    localparam logic [5:0] INS_LH      = 6'd18;
    localparam logic [5:0] INS_LHU     = 6'd19;
    localparam logic [5:0] INS_LW      = 6'd20;
    localparam logic [5:0] LOAD_END    = 6'd20;

    localparam logic [5:0] INS_SB      = 6'd21;
    localparam logic [5:0] INS_SH      = 6'd22;
    localparam logic [5:0] INS_SW      = 6'd23;

    localparam logic [5:0] ICAL_BEGIN  = 6'd24;
    localparam logic [5:0] INS_ADDI    = 6'd24;
    localparam logic [5:0] ICAL_END    = 6'd35;

    localparam logic [5:0] INS_BEQ     = 6'd36;
    localparam logic [5:0] INS_J       = 6'd42;
    localparam logic [5:0] INS_JAL     = 6'd43;
    localparam logic [5:0] INS_JALR    = 6'd44;

    typedef enum logic {
        MUX_WBDATA_MEM      = 1'b0,
        MUX_WBDATA_LINKADDR = 1'b1
    } wb_src_e;

    function automatic logic is_load(input logic [5:0] t);
        return (t >= LOAD_BEGIN) && (t <= LOAD_END);
    endfunction

    function automatic logic is_link(input logic [5:0] t);
        return (t == INS_JAL) || (t == INS_JALR);
    endfunction

    function automatic logic rf_wr_en(input logic [5:0] t);
        return ((t >= RCAL_BEGIN) && (t <= SHIFT_END)) || is_load(t) ||
               ((t >= ICAL_BEGIN) && (t <= ICAL_END)) || is_link(t);
    endfunction

    function automatic wb_src_e wb_src(input logic [5:0] t);
        return is_link(t) ? MUX_WBDATA_LINKADDR : MUX_WBDATA_MEM;
    endfunction

endpackage

// File: rtl/mem_wb_stage_load_aligner.sv
// Combinational load aligner: picks the byte/halfword addressed by addr and sign- or zero-extends it.
module load_aligner
    import mem_wb_stage_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [5:0]    ins_type,
    input  logic [1:0]    addr,
    input  logic [DW-1:0] word,
    output logic [DW-1:0] value
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    assign byte_s = word[{addr, 3'b000} +: 8];
    assign half_s = addr[1] ? word[31:16] : word[15:0];

    // Extension select; non-load types pass the raw word through.
    always_comb begin
        value = word;
        case (ins_type)
            INS_LB:  value = {{(DW-8){byte_s[7]}}, byte_s};
            INS_LBU: value = {{(DW-8){1'b0}}, byte_s};
            INS_LH:  value = {{(DW-16){half_s[15]}}, half_s};
            INS_LHU: value = {{(DW-16){1'b0}}, half_s};
            INS_LW:  value = word;
            default: value = word;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with write-back decode, load alignment and retire counter.
// Optional WB_MISALIGN_CHECK_EN adds wb_misalign and blocks writes of misaligned loads.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DW    = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_valid,
    input  logic [5:0]       mem_insType,
    input  logic [4:0]       mem_rd,
    input  logic [DW-1:0]    mem_aluResult,
    input  logic [DW-1:0]    mem_rdata,
    input  logic [DW-1:0]    mem_linkAddr,
    input  logic             stall,
    input  logic             flush,
    output logic             wb_valid,
    output logic [5:0]       wb_insType,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [DW-1:0]    rf_wdata,
    output logic             fwd_valid,
    output logic [CNT_W-1:0] retire_cnt
`ifdef WB_MISALIGN_CHECK_EN
    ,
    output logic             wb_misalign
`endif
);

    logic             valid_r;
    logic [5:0]       ins_r;
    logic [4:0]       rd_r;
    logic [DW-1:0]    alu_r;
    logic [DW-1:0]    rdata_r;
    logic [DW-1:0]    link_r;
    logic             written_r;
    logic [CNT_W-1:0] cnt_r;

    logic [DW-1:0]    aligned_s;
    logic             misalign_s;
    logic             we_s;
    logic [DW-1:0]    wdata_s;

    load_aligner #(.DW(DW)) u_load_aligner (
        .ins_type (ins_r),
        .addr     (alu_r[1:0]),
        .word     (rdata_r),
        .value    (aligned_s)
    );

`ifdef WB_MISALIGN_CHECK_EN
    assign misalign_s = valid_r &&
                        ((((ins_r == INS_LH) || (ins_r == INS_LHU)) && alu_r[0]) ||
                         ((ins_r == INS_LW) && (alu_r[1:0] != 2'b00)));
    assign wb_misalign = misalign_s;
`else
    assign misalign_s = 1'b0;
`endif

    // An entry held by stall writes only in its first WB cycle, tracked by written_r.
    assign we_s = valid_r && rf_wr_en(ins_r) && (rd_r != 5'd0) && !written_r && !misalign_s;

    // Write-back data source select.
    always_comb begin
        wdata_s = alu_r;
        if (wb_src(ins_r) == MUX_WBDATA_LINKADDR) begin
            wdata_s = link_r;
        end else if (is_load(ins_r)) begin
            wdata_s = aligned_s;
        end else begin
            wdata_s = alu_r;
        end
    end

    // Pipeline register capture: rst > flush > stall > load.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r   <= 1'b0;
            ins_r     <= 6'd0;
            rd_r      <= 5'd0;
            alu_r     <= '0;
            rdata_r   <= '0;
            link_r    <= '0;
            written_r <= 1'b0;
        end else if (flush) begin
            valid_r   <= 1'b0;
            written_r <= 1'b0;
        end else if (stall) begin
            written_r <= written_r | we_s;
        end else begin
            valid_r   <= mem_valid;
            ins_r     <= mem_insType;
            rd_r      <= mem_rd;
            alu_r     <= mem_aluResult;
            rdata_r   <= mem_rdata;
            link_r    <= mem_linkAddr;
            written_r <= 1'b0;
        end
    end

    // Retire counter: an instruction retires as it leaves WB; wraps freely.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (valid_r && !stall && !flush) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign wb_valid   = valid_r;
    assign wb_insType = ins_r;
    assign rf_we      = we_s;
    assign rf_waddr   = rd_r;
    assign rf_wdata   = wdata_s;
    assign fwd_valid  = we_s;
    assign retire_cnt = cnt_r;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: vector table plus stall/flush/reset/wrap sequences.
module tb_mem_wb_stage;
    import mem_wb_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst, mem_valid, stall, flush;
    logic [5:0]  mem_insType;
    logic [4:0]  mem_rd;
    logic [31:0] mem_aluResult, mem_rdata, mem_linkAddr;
    logic        wb_valid, rf_we, fwd_valid;
    logic [5:0]  wb_insType;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [3:0]  retire_cnt;
`ifdef WB_MISALIGN_CHECK_EN
    logic        wb_misalign;
`endif

    int total = 0;
    int bad   = 0;
    logic [3:0] exp_cnt = 4'd0;
    logic       m_valid = 1'b0;

    always #5 clk = ~clk;

    mem_wb_stage #(.DW(32), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_insType(mem_insType),
        .mem_rd(mem_rd), .mem_aluResult(mem_aluResult), .mem_rdata(mem_rdata),
        .mem_linkAddr(mem_linkAddr), .stall(stall), .flush(flush),
        .wb_valid(wb_valid), .wb_insType(wb_insType), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .fwd_valid(fwd_valid),
        .retire_cnt(retire_cnt)
`ifdef WB_MISALIGN_CHECK_EN
        , .wb_misalign(wb_misalign)
`endif
    );

    typedef struct {
        logic        v;
        logic [5:0]  ins;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] link;
        logic        we;
        logic [31:0] wdata;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Counter model updated from the controls in force at the coming edge.
    task automatic tick();
        if (rst) begin
            exp_cnt = 4'd0;
            m_valid = 1'b0;
        end else begin
            if (m_valid && !stall && !flush) exp_cnt = exp_cnt + 4'd1;
            if (flush) m_valid = 1'b0;
            else if (!stall) m_valid = mem_valid;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] ins, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] rdata, input logic [31:0] link);
        mem_valid = v; mem_insType = ins; mem_rd = rd;
        mem_aluResult = alu; mem_rdata = rdata; mem_linkAddr = link;
    endtask

    task automatic check_cnt(input string name);
        check(name, {28'd0, retire_cnt}, {28'd0, exp_cnt});
    endtask

    initial begin
        vecs[0]  = '{1'b1, INS_ADDI, 5'd5,  32'h12345678, 32'h0,        32'h0,        1'b1, 32'h12345678};
        vecs[1]  = '{1'b1, INS_LB,   5'd6,  32'h00001003, 32'h80FFFFFF, 32'h0,        1'b1, 32'hFFFFFF80};
        vecs[2]  = '{1'b1, INS_LBU,  5'd6,  32'h00001003, 32'h80FFFFFF, 32'h0,        1'b1, 32'h00000080};
        vecs[3]  = '{1'b1, INS_LH,   5'd7,  32'h00002002, 32'h80017FFF, 32'h0,        1'b1, 32'hFFFF8001};
        vecs[4]  = '{1'b1, INS_LHU,  5'd7,  32'h00002002, 32'h80017FFF, 32'h0,        1'b1, 32'h00008001};
        vecs[5]  = '{1'b1, INS_LW,   5'd8,  32'h00000100, 32'hDEADBEEF, 32'h0,        1'b1, 32'hDEADBEEF};
        vecs[6]  = '{1'b1, INS_JAL,  5'd31, 32'h00000005, 32'h0,        32'h00400010, 1'b1, 32'h00400010};
        vecs[7]  = '{1'b1, INS_SW,   5'd3,  32'h00000004, 32'h0,        32'h0,        1'b0, 32'h00000004};
        vecs[8]  = '{1'b1, INS_BEQ,  5'd9,  32'h00000000, 32'h0,        32'h0,        1'b0, 32'h00000000};
        vecs[9]  = '{1'b1, INS_ADDI, 5'd0,  32'h00000055, 32'h0,        32'h0,        1'b0, 32'h00000055};
        vecs[10] = '{1'b0, INS_ADDI, 5'd4,  32'h00000001, 32'h0,        32'h0,        1'b0, 32'h00000001};
        vecs[11] = '{1'b1, INS_JALR, 5'd1,  32'h00000009, 32'h0,        32'h00000080, 1'b1, 32'h00000080};
        vecs[12] = '{1'b1, INS_ADD,  5'd2,  32'h0000A5A5, 32'h0,        32'h0,        1'b1, 32'h0000A5A5};
        vecs[13] = '{1'b1, INS_SLL,  5'd3,  32'h00000010, 32'h0,        32'h0,        1'b1, 32'h00000010};
        vecs[14] = '{1'b1, INS_J,    5'd31, 32'h00000007, 32'h0,        32'h0,        1'b0, 32'h00000007};
        vecs[15] = '{1'b1, INS_LB,   5'd8,  32'h00000001, 32'h00007F00, 32'h0,        1'b1, 32'h0000007F};

        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(1'b1, INS_ADDI, 5'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        tick(); tick();
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_rf_we", {31'd0, rf_we}, 32'd0);
        check("rst_waddr", {27'd0, rf_waddr}, 32'd0);
        check("rst_wdata", rf_wdata, 32'd0);
        check("rst_ins", {26'd0, wb_insType}, 32'd0);
        check_cnt("rst_cnt");
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].v, vecs[i].ins, vecs[i].rd, vecs[i].alu, vecs[i].rdata, vecs[i].link);
            tick();
            check($sformatf("v%0d_valid", i), {31'd0, wb_valid}, {31'd0, vecs[i].v});
            check($sformatf("v%0d_ins", i), {26'd0, wb_insType}, {26'd0, vecs[i].ins});
            check($sformatf("v%0d_we", i), {31'd0, rf_we}, {31'd0, vecs[i].we});
            check($sformatf("v%0d_fwd", i), {31'd0, fwd_valid}, {31'd0, vecs[i].we});
            check($sformatf("v%0d_waddr", i), {27'd0, rf_waddr}, {27'd0, vecs[i].rd});
            check($sformatf("v%0d_wdata", i), rf_wdata, vecs[i].wdata);
            check_cnt($sformatf("v%0d_cnt", i));
        end

        // Stall hold: write once, stable outputs, single retirement on release.
        drive(1'b1, INS_ADDI, 5'd10, 32'h0000CAFE, 32'h0, 32'h0);
        tick();
        check("stall_first_we", {31'd0, rf_we}, 32'd1);
        stall = 1'b1;
        drive(1'b1, INS_ADDI, 5'd11, 32'h11111111, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall%0d_we", i), {31'd0, rf_we}, 32'd0);
            check($sformatf("stall%0d_valid", i), {31'd0, wb_valid}, 32'd1);
            check($sformatf("stall%0d_waddr", i), {27'd0, rf_waddr}, 32'd10);
            check($sformatf("stall%0d_wdata", i), rf_wdata, 32'h0000CAFE);
            check_cnt($sformatf("stall%0d_cnt", i));
        end
        stall = 1'b0;
        drive(1'b0, INS_NOP, 5'd0, 32'h0, 32'h0, 32'h0);
        tick();
        check("release_valid", {31'd0, wb_valid}, 32'd0);
        check_cnt("release_cnt");

        // Flush beats stall.
        drive(1'b1, INS_ADDI, 5'd12, 32'h00000033, 32'h0, 32'h0);
        tick();
        stall = 1'b1; flush = 1'b1;
        tick();
        check("flush_valid", {31'd0, wb_valid}, 32'd0);
        check("flush_we", {31'd0, rf_we}, 32'd0);
        check_cnt("flush_cnt");
        stall = 1'b0; flush = 1'b0;

        // Reset mid-stream beats stall and flush.
        drive(1'b1, INS_JAL, 5'd31, 32'h00000044, 32'h0, 32'h00000888);
        tick();
        tick();
        rst = 1'b1; stall = 1'b1; flush = 1'b1;
        tick();
        check("mrst_valid", {31'd0, wb_valid}, 32'd0);
        check("mrst_we", {31'd0, rf_we}, 32'd0);
        check("mrst_waddr", {27'd0, rf_waddr}, 32'd0);
        check("mrst_wdata", rf_wdata, 32'd0);
        check("mrst_cnt", {28'd0, retire_cnt}, 32'd0);
        rst = 1'b0; stall = 1'b0; flush = 1'b0;

        // 17 retirements on a 4-bit counter wrap to 1.
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, INS_ADDI, 5'd1, i, 32'h0, 32'h0);
            tick();
        end
        drive(1'b0, INS_NOP, 5'd0, 32'h0, 32'h0, 32'h0);
        tick();
        check("wrap_cnt", {28'd0, retire_cnt}, 32'd1);

`ifdef WB_MISALIGN_CHECK_EN
        drive(1'b1, INS_LW, 5'd4, 32'h00000002, 32'h12345678, 32'h0);
        tick();
        check("mis_flag", {31'd0, wb_misalign}, 32'd1);
        check("mis_we", {31'd0, rf_we}, 32'd0);
        drive(1'b1, INS_LW, 5'd4, 32'h00000004, 32'h12345678, 32'h0);
        tick();
        check("aligned_flag", {31'd0, wb_misalign}, 32'd0);
        check("aligned_we", {31'd0, rf_we}, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
